decode_issue_buffer: RTL and testbench
======================================

Name: decode_issue_buffer

Overview:
- Producer side of the format-specific decoder input interface. Sits between fetch and the per-format decoders (D, B, I, SC, ...).
- Accepts fetched instruction words over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Tags each accepted word with a 64-bit major ID and classifies its primary opcode into the one-hot instFormat code.
- Issues entries to decode with an enable/stall handshake.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction word width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- PrimOpcodeSize, 6, primary opcode width
- formatWidth, 26, instFormat vector width
- D, 2**5, format code for D-form
- B, 2**1, format code for B-form
- I, 2**4, format code for I-form
- SC, 2**3, format code for SC-form

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- fetchValid_i  in  1  fetch offers a word
- fetchReady_o  out  1  buffer can accept a word
- instruction_i  in  instructionWidth  fetched word, bit 0 = MSB
- instructionAddress_i  in  addressWidth  address of the word
- is64Bit_i  in  1  64-bit mode flag
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- flush_i  in  1  discard all buffered entries
- stall_i  in  1  decode cannot accept this cycle
- enable_o  out  1  issued entry valid
- instFormat_o  out  formatWidth  one-hot format code
- instructionOpcode_o  out  PrimOpcodeSize  bits [0:5] of the word
- instruction_o  out  instructionWidth  word
- instructionAddress_o  out  addressWidth  address
- is64Bit_o  out  1  mode flag
- instructionPid_o  out  PidSize  process ID
- instructionTid_o  out  TidSize  thread ID
- instructionMajId_o  out  instructionCounterWidth  major ID

Behaviour:
- Clock and reset: one clock, clock_i. Reset is synchronous and active-high, on reset_i. All state changes on the rising edge.
- Reset values: FIFO count 0; majId counter 0; enable_o 0; all data outputs 0; fetchReady_o 1 from the first post-reset cycle.
- FIFO: 2 entries, head/tail pointers, 2-bit count (0..2).
- Outputs are driven directly from the head entry's registers; there is no combinational path from the inputs. enable_o = (count != 0).
- Push condition: fetchValid_i && fetchReady_o && !flush_i.
  - fetchReady_o = (count < 2), registered-count based.
  - At full, fetchReady_o is 0 even if a pop happens in the same cycle; there is no pass-through.
- Pop condition: enable_o && !stall_i && !flush_i.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- At push, the entry stores:
  - majId = current counter value; the counter then increments by 1 and wraps 2^64-1 -> 0.
  - opcode = instruction_i[0:5].
  - format code, from the primary opcode:
    - D for {2,3,7,8,10..15,24..29,32..55}
    - B for 16
    - SC for 17
    - I for 18
    - all others 0 (unclassified; still issued with enable_o = 1).
- Latency: a word pushed into an empty FIFO in cycle N appears with enable_o = 1 in cycle N+1.
- While stall_i = 1: enable_o and all data outputs hold stable and the head entry is not consumed.
- Pointer wrap: pointers are 1 bit wide and wrap naturally.
- flush_i (highest priority after reset): count <- 0, pointers <- 0, enable_o = 0 next cycle. Any push in the flush cycle is dropped. The majId counter is not rewound, so IDs stay unique.
- reset_i mid-operation: full reset to the reset values above, including the majId counter.
- Data outputs while enable_o = 0: hold the last head contents; consumers ignore them.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- When defined:
  - Adds outputs issuedCount_o (32 bits) and stallCycles_o (32 bits).
  - issuedCount_o increments on each pop.
  - stallCycles_o increments on each cycle with enable_o && stall_i.
  - Both saturate at 2^32-1 and clear on reset_i only; flush_i does not clear them.
- When undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
- After reset, push opcode 14 (addi) at address 0x100, no stall -> next cycle enable_o = 1, instFormat_o = 2**5, instructionOpcode_o = 14, instructionMajId_o = 0, instructionAddress_o = 0x100; cycle after that enable_o = 0.
- Push opcodes 16, 17, 18, 31 back to back, no stall -> instFormat_o sequence B, SC, I, 0; majIds 0, 1, 2, 3.
- Hold stall_i = 1, offer 3 words -> first 2 accepted, fetchReady_o = 0 at count 2, outputs frozen on majId 0. Release stall -> majIds 0, 1 issued, then the third word issues as majId 2.
- Full FIFO with stall_i = 0 and fetchValid_i = 1 -> no push in the full cycle (fetchReady_o = 0); the push succeeds the following cycle.
- Two words buffered, assert flush_i with a concurrent fetchValid_i -> next cycle enable_o = 0 and count 0. The next pushed word gets majId 2, not 0.
- Preload the counter to 2^64-1 via a testbench force, then push 2 words -> majIds 0xFFFF_FFFF_FFFF_FFFF, then 0. Assert reset_i mid-stream -> enable_o = 0 and the next push gets majId 0.

Source files
------------

// File: rtl/decode_issue_buffer.sv
// Two-entry issue buffer between fetch and the per-format decoders: tags words with a major ID and one-hot format code.
// Optional macro ISSUE_STATS_EN adds saturating issue/stall statistics outputs.
module decode_issue_buffer #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned PrimOpcodeSize          = 6,
  parameter int unsigned formatWidth             = 26,
  parameter int unsigned D                       = 2**5,
  parameter int unsigned B                       = 2**1,
  parameter int unsigned I                       = 2**4,
  parameter int unsigned SC                      = 2**3
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [0:instructionWidth-1]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  output logic                               enable_o,
  output logic [formatWidth-1:0]             instFormat_o,
  output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
  output logic [0:instructionWidth-1]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]                        issuedCount_o,
  output logic [31:0]                        stallCycles_o
`endif
);

  localparam int unsigned depth = 2;

  typedef struct packed {
    logic [instructionWidth-1:0]        instr;
    logic [addressWidth-1:0]            address;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] majId;
    logic [PrimOpcodeSize-1:0]          opcode;
    logic [formatWidth-1:0]             format;
  } issueEntry_t;

  // Primary opcode to one-hot decoder format; unknown opcodes map to zero.
  function automatic logic [formatWidth-1:0] classify(input logic [PrimOpcodeSize-1:0] opc);
    logic [formatWidth-1:0] fmt;
    fmt = '0;
    if (opc inside {6'd2, 6'd3, 6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29], [6'd32:6'd55]})
      fmt = formatWidth'(D);
    else if (opc == 6'd16)
      fmt = formatWidth'(B);
    else if (opc == 6'd17)
      fmt = formatWidth'(SC);
    else if (opc == 6'd18)
      fmt = formatWidth'(I);
    return fmt;
  endfunction

  issueEntry_t                        fifo [depth];
  issueEntry_t                        headReg;
  issueEntry_t                        newEntry;
  issueEntry_t                        nextOut;
  logic [1:0]                         count;
  logic [1:0]                         nextCount;
  logic                               headPtr;
  logic                               tailPtr;
  logic                               nextHead;
  logic                               push;
  logic                               pop;
  logic [instructionCounterWidth-1:0] majIdCounter;

  assign fetchReady_o = (count < 2'(depth));
  assign enable_o     = (count != 2'd0);

  // Handshake decode and selection of the entry that becomes head next cycle.
  always_comb begin
    push              = fetchValid_i && fetchReady_o && !flush_i;
    pop               = enable_o && !stall_i && !flush_i;
    newEntry          = '0;
    newEntry.instr    = instruction_i;
    newEntry.address  = instructionAddress_i;
    newEntry.is64Bit  = is64Bit_i;
    newEntry.pid      = instructionPid_i;
    newEntry.tid      = instructionTid_i;
    newEntry.majId    = majIdCounter;
    newEntry.opcode   = instruction_i[0:PrimOpcodeSize-1];
    newEntry.format   = classify(instruction_i[0:PrimOpcodeSize-1]);
    nextHead          = headPtr ^ pop;
    nextCount         = count;
    if (push && !pop)
      nextCount = count + 2'd1;
    else if (pop && !push)
      nextCount = count - 2'd1;
    nextOut = (push && (tailPtr == nextHead)) ? newEntry : fifo[nextHead];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count   <= 2'd0;
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
      headReg <= '0;
    end else if (flush_i) begin
      count   <= 2'd0;
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
    end else begin
      if (push)
        fifo[tailPtr] <= newEntry;
      tailPtr <= tailPtr ^ push;
      headPtr <= nextHead;
      count   <= nextCount;
      // Output copy only refreshes while something is queued, so data holds when idle.
      if (nextCount != 2'd0)
        headReg <= nextOut;
    end
  end

  // Major ID counter survives flush so IDs stay unique; wraps naturally.
  always_ff @(posedge clock_i) begin
    if (reset_i)
      majIdCounter <= '0;
    else
      majIdCounter <= majIdCounter + instructionCounterWidth'(push);
  end

  assign instFormat_o         = headReg.format;
  assign instructionOpcode_o  = headReg.opcode;
  assign instruction_o        = headReg.instr;
  assign instructionAddress_o = headReg.address;
  assign is64Bit_o            = headReg.is64Bit;
  assign instructionPid_o     = headReg.pid;
  assign instructionTid_o     = headReg.tid;
  assign instructionMajId_o   = headReg.majId;

`ifdef ISSUE_STATS_EN
  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      issuedCount_o <= '0;
      stallCycles_o <= '0;
    end else begin
      if (pop && (issuedCount_o != '1))
        issuedCount_o <= issuedCount_o + 32'd1;
      if (enable_o && stall_i && (stallCycles_o != '1))
        stallCycles_o <= stallCycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed self-checking bench for decode_issue_buffer: formats, major IDs, stall, full, flush, wrap, reset.
module tb_decode_issue_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchValid;
  logic        fetchReady;
  logic [0:31] instruction;
  logic [63:0] instructionAddress;
  logic        is64Bit;
  logic [19:0] instructionPid;
  logic [15:0] instructionTid;
  logic        flush;
  logic        stall;
  logic        enable;
  logic [25:0] instFormat;
  logic [5:0]  instructionOpcode;
  logic [0:31] instructionOut;
  logic [63:0] instructionAddressOut;
  logic        is64BitOut;
  logic [19:0] instructionPidOut;
  logic [15:0] instructionTidOut;
  logic [63:0] instructionMajId;
`ifdef ISSUE_STATS_EN
  logic [31:0] issuedCount;
  logic [31:0] stallCycles;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  decode_issue_buffer dut (
    .clock_i              (clk),
    .reset_i              (reset),
    .fetchValid_i         (fetchValid),
    .fetchReady_o         (fetchReady),
    .instruction_i        (instruction),
    .instructionAddress_i (instructionAddress),
    .is64Bit_i            (is64Bit),
    .instructionPid_i     (instructionPid),
    .instructionTid_i     (instructionTid),
    .flush_i              (flush),
    .stall_i              (stall),
    .enable_o             (enable),
    .instFormat_o         (instFormat),
    .instructionOpcode_o  (instructionOpcode),
    .instruction_o        (instructionOut),
    .instructionAddress_o (instructionAddressOut),
    .is64Bit_o            (is64BitOut),
    .instructionPid_o     (instructionPidOut),
    .instructionTid_o     (instructionTidOut),
    .instructionMajId_o   (instructionMajId)
`ifdef ISSUE_STATS_EN
    ,
    .issuedCount_o        (issuedCount),
    .stallCycles_o        (stallCycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [5:0] opc, input logic [63:0] addr);
    fetchValid         = 1'b1;
    instruction        = {opc, 26'(addr)};
    instructionAddress = addr;
  endtask

  task automatic doReset();
    reset      = 1'b1;
    fetchValid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [5:0]  opcs [4] = '{6'd16, 6'd17, 6'd18, 6'd31};
  logic [25:0] fmts [4] = '{26'd2, 26'd8, 26'd16, 26'd0};

  initial begin
    reset              = 1'b1;
    fetchValid         = 1'b0;
    instruction        = '0;
    instructionAddress = '0;
    is64Bit            = 1'b1;
    instructionPid     = 20'h12345;
    instructionTid     = 16'hbeef;
    flush              = 1'b0;
    stall              = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_enable", 64'(enable), 64'd0);
    check("rst_ready", 64'(fetchReady), 64'd1);
    check("rst_majid", instructionMajId, 64'd0);
    check("rst_format", 64'(instFormat), 64'd0);
    check("rst_addr", instructionAddressOut, 64'd0);
    reset = 1'b0;

    // Single addi word
    offer(6'd14, 64'h100);
    step();
    fetchValid = 1'b0;
    check("t1_enable", 64'(enable), 64'd1);
    check("t1_format", 64'(instFormat), 64'd32);
    check("t1_opcode", 64'(instructionOpcode), 64'd14);
    check("t1_majid", instructionMajId, 64'd0);
    check("t1_addr", instructionAddressOut, 64'h100);
    check("t1_pid", 64'(instructionPidOut), 64'h12345);
    check("t1_tid", 64'(instructionTidOut), 64'hbeef);
    check("t1_is64", 64'(is64BitOut), 64'd1);
    step();
    check("t1_enable_off", 64'(enable), 64'd0);
    check("t1_addr_hold", instructionAddressOut, 64'h100);

    // Back-to-back format classes
    doReset();
    for (int k = 0; k < 4; k++) begin
      offer(opcs[k], 64'h200 + 64'(4 * k));
      step();
      check($sformatf("t2_enable%0d", k), 64'(enable), 64'd1);
      check($sformatf("t2_format%0d", k), 64'(instFormat), 64'(fmts[k]));
      check($sformatf("t2_majid%0d", k), instructionMajId, 64'(k));
    end
    fetchValid = 1'b0;
    step();
    check("t2_enable_off", 64'(enable), 64'd0);

    // Stall fills the buffer, then full-cycle push is refused
    doReset();
    stall = 1'b1;
    offer(6'd14, 64'h300);
    check("t3_ready0", 64'(fetchReady), 64'd1);
    step();
    check("t3_enable", 64'(enable), 64'd1);
    check("t3_majid_a", instructionMajId, 64'd0);
    offer(6'd16, 64'h304);
    step();
    check("t3_ready_full", 64'(fetchReady), 64'd0);
    check("t3_majid_b", instructionMajId, 64'd0);
    offer(6'd17, 64'h308);
    step();
    check("t3_ready_full2", 64'(fetchReady), 64'd0);
    check("t3_majid_frozen", instructionMajId, 64'd0);
    check("t3_addr_frozen", instructionAddressOut, 64'h300);
    stall = 1'b0;
    step();
    check("t3_majid_1", instructionMajId, 64'd1);
    check("t3_format_1", 64'(instFormat), 64'd2);
    check("t3_ready_after", 64'(fetchReady), 64'd1);
    step();
    fetchValid = 1'b0;
    check("t3_majid_2", instructionMajId, 64'd2);
    check("t3_format_2", 64'(instFormat), 64'd8);
    check("t3_addr_2", instructionAddressOut, 64'h308);
    step();
    check("t3_enable_off", 64'(enable), 64'd0);

    // Flush with a concurrent offer
    doReset();
    stall = 1'b1;
    offer(6'd14, 64'h400);
    step();
    offer(6'd16, 64'h404);
    step();
    check("t5_full", 64'(fetchReady), 64'd0);
    flush = 1'b1;
    stall = 1'b0;
    offer(6'd17, 64'h408);
    step();
    flush = 1'b0;
    check("t5_enable_flushed", 64'(enable), 64'd0);
    check("t5_ready_flushed", 64'(fetchReady), 64'd1);
    offer(6'd18, 64'h40c);
    step();
    fetchValid = 1'b0;
    check("t5_enable", 64'(enable), 64'd1);
    check("t5_majid", instructionMajId, 64'd2);
    check("t5_format", 64'(instFormat), 64'd16);
    step();
    check("t5_enable_off", 64'(enable), 64'd0);

    // Counter wrap, then reset mid-stream
    doReset();
    force dut.majIdCounter = '1;
    step();
    release dut.majIdCounter;
    offer(6'd14, 64'h500);
    step();
    check("t6_majid_max", instructionMajId, 64'hFFFF_FFFF_FFFF_FFFF);
    offer(6'd16, 64'h504);
    step();
    check("t6_majid_wrap", instructionMajId, 64'd0);
    check("t6_format_wrap", 64'(instFormat), 64'd2);
    offer(6'd17, 64'h508);
    step();
    check("t6_majid_1", instructionMajId, 64'd1);
    reset = 1'b1;
    offer(6'd18, 64'h50c);
    step();
    reset = 1'b0;
    check("t6_rst_enable", 64'(enable), 64'd0);
    check("t6_rst_addr", instructionAddressOut, 64'd0);
    offer(6'd18, 64'h510);
    step();
    fetchValid = 1'b0;
    check("t6_post_enable", 64'(enable), 64'd1);
    check("t6_post_majid", instructionMajId, 64'd0);
    check("t6_post_format", 64'(instFormat), 64'd16);
    check("t6_post_addr", instructionAddressOut, 64'h510);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
